instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the RISC-V datapath. Holds the PC, fetches words from instruction memory over a request/response handshake, and buffers them in a small FIFO.
- Presents instruction, PC and opcode (instr_op) to the control unit / decode stage with a valid/ready handshake.
- Decode and branch logic can redirect the PC, which flushes all in-flight and buffered fetches.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC loaded on reset
BUF_DEPTH, 2, instruction FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address, word aligned
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  XLEN  response instruction word
redirect_valid  input  1  PC redirect (taken branch), one-cycle pulse
redirect_pc  input  XLEN  redirect target
instr_valid  output  1  buffer head valid
instr_ready  input  1  decode consumes head
instr  output  XLEN  head instruction
instr_pc  output  XLEN  head PC
instr_op  output  7  instr[6:0], drives control_unit instr_op
instr_illegal  output  1  head opcode unsupported (see Optional Feature)

Behaviour:
- Reset: pc=RESET_PC, FIFO empty, state=FETCH, imem_req=0, instr_valid=0, instr_illegal=0. Outputs are registered or derived from registers.
- Outstanding requests: at most one. The request handshake completes on imem_req&imem_ready. The response arrives in a later cycle, never the same cycle.
- FSM states: FETCH, WAIT, DROP.
- FETCH:
  - imem_req=1 iff count<BUF_DEPTH.
  - imem_addr=pc.
  - On accept: pc<=pc+4, go to WAIT.
  - imem_req/imem_addr hold stable until accepted.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: push {pc_of_request, imem_rdata}, go to FETCH.
  - A free slot is guaranteed because count<BUF_DEPTH was checked at issue and pops only free space.
- DROP:
  - imem_req=0.
  - On imem_rvalid: discard data, go to FETCH.
- Redirect (highest priority):
  - FIFO flushed (count<=0, instr_valid=0 next cycle).
  - pc<=redirect_pc with bits[1:0] forced to 0.
  - Next state: if in WAIT, or a request is accepted in the same cycle, go to DROP. If in DROP, stay in DROP. Otherwise go to FETCH.
  - An imem_rvalid arriving in the redirect cycle is discarded, and the state then goes to FETCH rather than DROP.
- FIFO:
  - Pop on instr_valid&instr_ready.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - Pop when empty is ignored.
  - A push that would overflow is impossible by construction. Bench asserts this.
- Decode outputs are driven from the FIFO head: instr_op=instr[6:0], instr_pc = PC of that word.
- PC arithmetic: modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0.
- Latency: with imem_ready=1 and a 1-cycle response, the first instr_valid after reset occurs in cycle 3 (request cycle 1, response cycle 2, visible cycle 3). Sustained throughput is one instruction per 2 cycles.

Optional Feature:
- Macro: IFU_OPCODE_CHECK_EN.
- Defined: instr_illegal = instr_valid and instr_op not in {0110011, 0000011, 0100011, 1100011}. This is registered alongside the FIFO entry at push time.
- Not defined: instr_illegal tied to 0. No checking logic is synthesized.

Test Plan:
- Reset, imem_ready=1, 1-cycle response, memory word at addr A = 32'h0000_0000 + 4k, instr_ready=1 -> instr_pc sequence 0,4,8,C. The instr_op at addr 0 is 0110011 when mem[0]=32'h0020_81B3.
- instr_ready=0 for 10 cycles -> exactly BUF_DEPTH=2 entries buffered, then imem_req=0. Release -> pops in order, no loss or duplication.
- redirect_valid with redirect_pc=32'h0000_0102 while in WAIT -> the stale response is discarded, the next imem_addr is 32'h0000_0100, and the FIFO is empty the next cycle.
- redirect in the same cycle as imem_rvalid, target 32'h40 -> data dropped, next request addr 32'h40, no DROP stall.
- imem_ready=0 for 5 cycles -> imem_req and imem_addr held stable, pc not incremented.
- With IFU_OPCODE_CHECK_EN, word 32'hFFFF_FFFF fetched -> instr_op=1111111 and instr_illegal=1. The 0100011 store word gives instr_illegal=0. Without the macro, instr_illegal is always 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Front end of the RISC-V datapath. Owns the PC, issues one word fetch at a
// time to instruction memory, and buffers returned words in a small FIFO that
// feeds the decode stage. A redirect (taken branch) reloads the PC and
// flushes everything buffered or in flight.
//
// Optional feature macro: IFU_OPCODE_CHECK_EN
//   defined   -> instr_illegal flags head words whose opcode is not one of
//                R-type, load, store or branch (flag computed at push time)
//   undefined -> instr_illegal is tied to 0, no checking logic exists
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   imem_req/addr    fetch request (registered) and word-aligned address
//   imem_ready       memory accepts the request this cycle
//   imem_rvalid/data response, always at least one cycle after acceptance
//   redirect_valid   one-cycle PC redirect pulse, target in redirect_pc
//   instr_valid      FIFO head valid; instr_ready consumes it
//   instr, instr_pc  head word and the PC it was fetched from
//   instr_op         instr[6:0] for the control unit
//   instr_illegal    head opcode unsupported (optional feature)
//
// Handshakes: a transfer happens on any rising edge where valid and ready
// are both high. A valid source holds its payload stable until that edge;
// ready may be asserted or dropped freely and never depends on valid.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      instr_op,
    output logic            instr_illegal
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc;          // next address to fetch
    logic [XLEN-1:0]   req_pc;      // address of the outstanding request
    logic [CNT_W-1:0]  count, count_n;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic              req_q;

    logic [XLEN-1:0]   buf_instr [BUF_DEPTH];
    logic [XLEN-1:0]   buf_pc    [BUF_DEPTH];

    logic accept, pop, push, flush, req_n;

    assign accept = req_q & imem_ready;
    assign pop    = instr_valid & instr_ready;

    // Next-state decode. Redirect wins over everything; a response landing
    // in the redirect cycle is simply discarded, so no DROP stall is needed.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
            if (imem_rvalid)
                state_n = FETCH;
            else if (state == WAIT || state == DROP || accept)
                state_n = DROP;
            else
                state_n = FETCH;
        end else begin
            unique case (state)
                FETCH: if (accept) state_n = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_n = FETCH;
                    end
                end
                DROP:  if (imem_rvalid) state_n = FETCH;
                default: state_n = FETCH;
            endcase
        end
    end

    // Pop of an empty FIFO cannot happen because pop is gated by instr_valid.
    always_comb begin
        if (flush)
            count_n = '0;
        else
            count_n = count + CNT_W'(push) - CNT_W'(pop);
    end

    // imem_req is registered from next-cycle state so it is glitch-free and
    // low during reset. Space is guaranteed at response time because the
    // count check is made before the request is ever raised.
    assign req_n = (state_n == FETCH) && (count_n < CNT_W'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            req_q  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            req_q <= req_n;
            if (flush) begin
                pc     <= redirect_pc & ~XLEN'(3);
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (accept) begin
                    pc     <= pc + XLEN'(4);
                    req_pc <= pc;
                end
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign instr       = buf_instr[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];
    assign instr_op    = instr[6:0];

`ifdef IFU_OPCODE_CHECK_EN
    logic buf_ill [BUF_DEPTH];
    logic rdata_ill;

    always_comb begin
        unique case (imem_rdata[6:0])
            7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: rdata_ill = 1'b0;
            default:                                        rdata_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) buf_ill[wr_ptr] <= rdata_ill;
    end

    assign instr_illegal = instr_valid & buf_ill[rd_ptr];
`else
    assign instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit with a behavioural instruction memory of variable
// response latency. A scoreboard records every accepted request (address and
// the word memory will return) and compares each decode-side pop against it;
// a redirect empties the expected queue. Directed sequences cover reset,
// first-fetch latency, backpressure, redirect in WAIT, redirect coincident
// with a response, memory stall, PC wrap, and a table of opcode vectors.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int XLEN      = 32;
    localparam int BUF_DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      instr_op;
    logic            instr_illegal;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_op       (instr_op),
        .instr_illegal  (instr_illegal)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int              checks   = 0;
    int              failures = 0;
    int              mem_lat  = 1;
    logic            override_en   = 1'b0;
    logic [31:0]     override_word = '0;
    logic [63:0]     exp_q[$];      // {pc, word} per accepted request
    logic [31:0]     pop_log[$];    // pcs popped by decode, in order

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic        ill;   // expected flag when the opcode check is built in
    } vec_t;
    vec_t tbl[6];

    // ---------------- models ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (override_en) return override_word;
        if (a == 32'h0) return 32'h0020_81B3;
        return {a[26:2], 7'b0110011};
    endfunction

    function automatic logic exp_ill(input logic [31:0] w);
`ifdef IFU_OPCODE_CHECK_EN
        return !(w[6:0] == 7'b0110011 || w[6:0] == 7'b0000011 ||
                 w[6:0] == 7'b0100011 || w[6:0] == 7'b1100011);
`else
        return 1'b0 & w[0];
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory ----------------
    task automatic memory_loop();
        logic        pend = 1'b0;
        int          wc   = 0;
        logic [31:0] pw   = '0;
        forever begin
            @(negedge clk);
            if (rst) pend = 1'b0;
            else if (imem_req && imem_ready) begin
                pend = 1'b1;
                pw   = mem_word(imem_addr);
                wc   = mem_lat;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pend) begin
                wc--;
                if (wc <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pw;
                    pend        = 1'b0;
                end
            end
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic monitor_loop();
        logic [31:0] exp_addr   = 32'h0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_addr  = 32'h0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_addr   = 32'h0;
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            prev_stall = imem_req && !imem_ready && !redirect_valid;
            prev_addr  = imem_addr;
            chk("no_overflow", {31'b0, (32'(dut.count) <= BUF_DEPTH)}, 32'd1);
            if (redirect_valid) begin
                exp_q.delete();
                exp_addr = redirect_pc & ~32'h3;
            end else begin
                if (imem_req && imem_ready) begin
                    chk("req_addr", imem_addr, exp_addr);
                    exp_q.push_back({imem_addr, mem_word(imem_addr)});
                    exp_addr = exp_addr + 32'd4;
                end
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pop_unexpected actual_pc=0x%08h required=none", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_pc", instr_pc, e[63:32]);
                        chk("pop_instr", instr, e[31:0]);
                        chk("pop_op", {25'b0, instr_op}, {25'b0, e[6:0]});
                        chk("pop_illegal", {31'b0, instr_illegal}, {31'b0, exp_ill(e[31:0])});
                    end
                    pop_log.push_back(instr_pc);
                end
            end
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic do_redirect(input logic [31:0] t);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = t;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_accept(output logic [31:0] a, output logic ok);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_ready) begin
                a  = imem_addr;
                ok = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a0, a1;
        logic        ok;
        int          n;
        logic        got;

        tbl[0] = '{32'hFFFF_FFFF, 7'b1111111, 1'b1};
        tbl[1] = '{32'h0011_2023, 7'b0100011, 1'b0};
        tbl[2] = '{32'h0020_81B3, 7'b0110011, 1'b0};
        tbl[3] = '{32'h0001_2083, 7'b0000011, 1'b0};
        tbl[4] = '{32'h0020_8463, 7'b1100011, 1'b0};
        tbl[5] = '{32'h0000_0013, 7'b0010011, 1'b1};

        rst            = 1'b1;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;

        fork
            memory_loop();
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_illegal", {31'b0, instr_illegal}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // First-fetch latency: request cycle 1, response 2, visible 3
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("c0_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("c1_req", {31'b0, imem_req}, 32'd1);
        chk("c1_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("c2_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("c3_valid", {31'b0, instr_valid}, 32'd1);
        chk("c3_pc", instr_pc, 32'h0);
        chk("c3_op", {25'b0, instr_op}, {25'b0, 7'b0110011});
        chk("c3_instr", instr, 32'h0020_81B3);
        repeat (8) @(negedge clk);
        #1;
        chk("seq_len_ge4", {31'b0, (pop_log.size() >= 4)}, 32'd1);
        if (pop_log.size() >= 4) begin
            chk("seq_pc0", pop_log[0], 32'h0);
            chk("seq_pc1", pop_log[1], 32'h4);
            chk("seq_pc2", pop_log[2], 32'h8);
            chk("seq_pc3", pop_log[3], 32'hC);
        end

        // Backpressure: buffer fills to depth, then fetching stops
        @(posedge clk); #1;
        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_count", 32'(dut.count), BUF_DEPTH);
        chk("bp_req", {31'b0, imem_req}, 32'd0);
        chk("bp_valid", {31'b0, instr_valid}, 32'd1);
        n = pop_log.size();
        @(posedge clk); #1;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("bp_drain_n", pop_log.size(), n + 2);
        if (pop_log.size() >= n + 2)
            chk("bp_order", pop_log[n+1], pop_log[n] + 32'd4);

        // Redirect while in WAIT with one entry buffered
        repeat (4) @(posedge clk);
        #1;
        mem_lat     = 3;
        instr_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (instr_valid && imem_req && imem_ready) got = 1'b1;
        end
        chk("wait_setup", {31'b0, got}, 32'd1);
        do_redirect(32'h0000_0102);
        @(negedge clk);
        chk("wr_valid_flushed", {31'b0, instr_valid}, 32'd0);
        chk("wr_drop_noreq", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (imem_req) got = 1'b1;
        end
        chk("wr_req_seen", {31'b0, got}, 32'd1);
        chk("wr_addr", imem_addr, 32'h0000_0100);

        // Redirect in the same cycle as a response
        @(posedge clk); #1;
        mem_lat = 1;
        repeat (6) @(posedge clk);
        wait_accept(a0, ok);
        chk("rv_setup", {31'b0, ok}, 32'd1);
        do_redirect(32'h0000_0040);
        @(negedge clk);
        chk("rv_req", {31'b0, imem_req}, 32'd1);
        chk("rv_addr", imem_addr, 32'h0000_0040);
        chk("rv_valid", {31'b0, instr_valid}, 32'd0);

        // Memory stall: request and address held, PC not advanced
        @(posedge clk); #1;
        imem_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (imem_req) got = 1'b1;
        end
        chk("st_req_seen", {31'b0, got}, 32'd1);
        a0 = imem_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("st_req", {31'b0, imem_req}, 32'd1);
            chk("st_addr", imem_addr, a0);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        wait_accept(a1, ok);
        chk("st_accept", {31'b0, ok}, 32'd1);
        chk("st_accept_addr", a1, a0);

        // PC wrap at the top of the address space
        do_redirect(32'hFFFF_FFFC);
        wait_accept(a0, ok);
        chk("wrap_top", a0, 32'hFFFF_FFFC);
        wait_accept(a1, ok);
        chk("wrap_zero", a1, 32'h0);

        // Opcode vectors
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            instr_ready    = 1'b0;
            override_en    = 1'b1;
            override_word  = tbl[i].word;
            redirect_valid = 1'b1;
            redirect_pc    = 32'h200 + 32'(i) * 32'd16;
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                @(negedge clk);
                if (instr_valid) got = 1'b1;
            end
            chk("vec_valid", {31'b0, got}, 32'd1);
            chk("vec_instr", instr, tbl[i].word);
            chk("vec_op", {25'b0, instr_op}, {25'b0, tbl[i].op});
`ifdef IFU_OPCODE_CHECK_EN
            chk("vec_illegal", {31'b0, instr_illegal}, {31'b0, tbl[i].ill});
`else
            chk("vec_illegal", {31'b0, instr_illegal}, 32'd0);
`endif
            chk("vec_pc", instr_pc, 32'h200 + 32'(i) * 32'd16);
            @(posedge clk); #1;
            instr_ready = 1'b1;
            repeat (6) @(posedge clk);
        end
        @(posedge clk); #1;
        override_en = 1'b0;
        do_redirect(32'h0000_1000);
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
